io_uart_tx_port: RTL and testbench

- Memory-mapped responder on the Risc32 data-side io bus: the target end of the `io_address` / `io_write_value` / `io_read_value` / `io_write_en` / `io_read_en` / `io_data_size` interface that the core initiates.
- Provides a byte transmit FIFO feeding an 8N1 UART serializer, a status register, a programmable baud divisor and a free-running cycle counter.
- Sits beside data memory; the system mux selects its `io_read_value` when `io_sel` is high.

---
 rtl/io_bus_pkg.sv | 38 +++
 rtl/io_sync_fifo.sv | 56 +++++
 rtl/io_uart_tx_port.sv | 196 +++++++++++++++++++
 tb/tb_io_uart_tx_port.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the Risc32 io-bus UART transmit port:
// register offsets, access-size encodings, serializer states, STATUS bit layout.
package io_bus_pkg;

  // Register offsets within the 16-byte window
  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_DIVISOR = 4'h8;
  localparam logic [3:0] OFF_CYCLES  = 4'hC;

  // io_data_size encodings (load/store funct3)
  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  // Serializer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // STATUS register bit positions
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  // True for the byte-wide store encodings (signed or unsigned)
  function automatic logic is_byte_size(input logic [2:0] size);
    return (size == SIZE_B) || (size == SIZE_BU);
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with occupancy count. Storage is not reset; only the
// pointers and count are. Pushes into a full FIFO and pops from an empty one
// are ignored.
module io_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; data path carries no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx_port.sv
// Memory-mapped UART transmit port on the Risc32 data-side io bus.
// TXDATA pushes bytes into a FIFO drained by an 8N1 serializer; STATUS,
// DIVISOR (clocks per bit) and a free-running CYCLES counter are also mapped.
module io_uart_tx_port
  import io_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter logic [15:0] CLKS_PER_BIT = 16'd868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_value,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [2:0]  io_data_size,
  output logic [31:0] io_read_value,
  output logic        io_sel,
  output logic        uart_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]  offset;
  logic        acc_ok;
  logic        wr_txdata;
  logic        wr_divisor;
  logic        wr_cycles;
  logic        rd_status;

  logic [15:0] divisor;
  logic [31:0] cycles;
  logic        overflow;

  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;

  uart_state_t state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_tick;
  logic [15:0] div_eff;
  logic [15:0] reload;

  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^io_write_value[31:16];

  // Address decode: only aligned accesses inside the window are honoured
  assign io_sel     = (io_address[31:4] == BASE_ADDR[31:4]);
  assign offset     = io_address[3:0];
  assign acc_ok     = io_sel && (io_address[1:0] == 2'b00);
  assign wr_txdata  = io_write_en && acc_ok && (offset == OFF_TXDATA);
  assign wr_divisor = io_write_en && acc_ok && (offset == OFF_DIVISOR);
  assign wr_cycles  = io_write_en && acc_ok && (offset == OFF_CYCLES);
  assign rd_status  = io_read_en  && acc_ok && (offset == OFF_STATUS);

  // A zero divisor would stall the baud counter, so it behaves as one
  assign div_eff  = (divisor == 16'd0) ? 16'd1 : divisor;
  assign reload   = div_eff - 16'd1;
  assign bit_tick = (baud_cnt == 16'd0);
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && bit_tick));

  io_sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .din   (io_write_value[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // DIVISOR: byte stores touch only the low byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor <= CLKS_PER_BIT;
    end else if (wr_divisor) begin
      if (is_byte_size(io_data_size)) divisor[7:0] <= io_write_value[7:0];
      else                            divisor     <= io_write_value[15:0];
    end
  end

  // CYCLES: free-running, a store clears it and wins over the increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cycles <= '0;
    else if (wr_cycles) cycles <= '0;
    else                cycles <= cycles + 32'd1;
  end

  // Sticky overflow: a dropped push sets it, a STATUS read clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        overflow <= 1'b0;
    else if (wr_txdata && fifo_full)  overflow <= 1'b1;
    else if (rd_status)               overflow <= 1'b0;
  end

  // Shift register: loaded on pop, shifted at each data-bit boundary
  always_ff @(posedge clk) begin
    if (fifo_pop)                           shreg <= fifo_dout;
    else if ((state == ST_DATA) && bit_tick) shreg <= {1'b0, shreg[7:1]};
  end

  // 8N1 serializer; the line level is registered alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state    <= ST_START;
            uart_tx  <= 1'b0;
            baud_cnt <= reload;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state    <= ST_DATA;
            uart_tx  <= shreg[0];
            bit_idx  <= 3'd0;
            baud_cnt <= reload;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            baud_cnt <= reload;
            if (bit_idx == 3'd7) begin
              state   <= ST_STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            baud_cnt <= reload;
            if (!fifo_empty) begin
              state   <= ST_START;
              uart_tx <= 1'b0;
            end else begin
              state   <= ST_IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

  // Combinational read mux, zero outside mapped aligned registers
  always_comb begin
    io_read_value = '0;
    if (acc_ok) begin
      case (offset)
        OFF_STATUS: begin
          io_read_value[STAT_FULL]  = fifo_full;
          io_read_value[STAT_EMPTY] = fifo_empty;
          io_read_value[STAT_BUSY]  = (state != ST_IDLE);
          io_read_value[STAT_OVF]   = overflow;
          io_read_value[STAT_CNT_LSB +: 8] = 8'(fifo_count);
        end
        OFF_DIVISOR: io_read_value = {16'd0, divisor};
        OFF_CYCLES:  io_read_value = cycles;
        default:     io_read_value = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx_port.sv
// Directed bench for io_uart_tx_port: register-access vector table followed by
// hand-written serializer, overflow, counter and reset sequences.
module tb_io_uart_tx_port;
  import io_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] io_address;
  logic [31:0] io_write_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [2:0]  io_data_size;
  logic [31:0] io_read_value;
  logic        io_sel;
  logic        uart_tx;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int last_cyc;

  bit         line_log [4096];
  logic [7:0] fbytes [16];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [2:0]  size;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_sel;
  } vec_t;

  vec_t vecs [15];

  io_uart_tx_port #(
    .BASE_ADDR    (32'h0000_1000),
    .CLKS_PER_BIT (16'd868),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .io_address     (io_address),
    .io_write_value (io_write_value),
    .io_write_en    (io_write_en),
    .io_read_en     (io_read_en),
    .io_data_size   (io_data_size),
    .io_read_value  (io_read_value),
    .io_sel         (io_sel),
    .uart_tx        (uart_tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line level after edge number cyc, captured on the falling edge
  always @(negedge clk) if (cyc < 4096) line_log[cyc] <= uart_tx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    io_address     = 32'h0;
    io_write_value = 32'h0;
    io_write_en    = 1'b0;
    io_read_en     = 1'b0;
    io_data_size   = SIZE_W;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
    io_address     = addr;
    io_write_value = data;
    io_write_en    = 1'b1;
    io_read_en     = 1'b0;
    io_data_size   = size;
    tick();
    last_cyc = cyc;
    bus_idle();
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] val);
    io_address   = addr;
    io_read_en   = 1'b1;
    io_write_en  = 1'b0;
    io_data_size = SIZE_W;
    #1;
    val = io_read_value;
    tick();
    bus_idle();
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  // Compare logged line against n back-to-back 8N1 frames of fbytes[], then idle
  task automatic check_frames(input string tag, input int start, input int div,
                              input int n, input int idle_n);
    int  idx;
    int  bad;
    bit  lvl;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 10; b++) begin
        if (b == 0)      lvl = 1'b0;
        else if (b == 9) lvl = 1'b1;
        else             lvl = fbytes[k][b-1];
        bad = 0;
        for (int c = 0; c < div; c++) begin
          idx = start + (k * 10 + b) * div + c;
          if (line_log[idx] != lvl) bad++;
        end
        check($sformatf("%s_frame%0d_bit%0d_badcycles", tag, k, b), bad, 0);
      end
    end
    for (int i = 0; i < idle_n; i++) begin
      idx = start + n * 10 * div + i;
      check($sformatf("%s_idle%0d", tag, i), {31'd0, line_log[idx]}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] rv;
    logic [31:0] ra;
    logic [31:0] rb;
    int p;

    vecs[0]  = '{32'h1004, 32'h0,        1'b0, 1'b1, SIZE_W,  1'b1, 32'h0000_0002, 1'b1};
    vecs[1]  = '{32'h1008, 32'h0,        1'b0, 1'b1, SIZE_W,  1'b1, 32'h0000_0364, 1'b1};
    vecs[2]  = '{32'h1000, 32'h0,        1'b0, 1'b1, SIZE_W,  1'b1, 32'h0000_0000, 1'b1};
    vecs[3]  = '{32'h1008, 32'h0000_1234, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h0,         1'b1};
    vecs[4]  = '{32'h1008, 32'hFFFF_FFAB, 1'b1, 1'b0, SIZE_B, 1'b0, 32'h0,         1'b1};
    vecs[5]  = '{32'h1008, 32'h0,        1'b0, 1'b1, SIZE_W,  1'b1, 32'h0000_12AB, 1'b1};
    vecs[6]  = '{32'h1009, 32'h0000_5555, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h0,         1'b1};
    vecs[7]  = '{32'h1008, 32'h0,        1'b0, 1'b1, SIZE_W,  1'b1, 32'h0000_12AB, 1'b1};
    vecs[8]  = '{32'h1009, 32'h0,        1'b0, 1'b1, SIZE_W,  1'b1, 32'h0000_0000, 1'b1};
    vecs[9]  = '{32'h2008, 32'h0000_7777, 1'b1, 1'b0, SIZE_W, 1'b1, 32'h0000_0000, 1'b0};
    vecs[10] = '{32'h1008, 32'h0,        1'b0, 1'b1, SIZE_W,  1'b1, 32'h0000_12AB, 1'b1};
    vecs[11] = '{32'h2004, 32'h0,        1'b0, 1'b1, SIZE_W,  1'b1, 32'h0000_0000, 1'b0};
    vecs[12] = '{32'h1008, 32'hFFFF_0004, 1'b1, 1'b0, SIZE_H, 1'b0, 32'h0,         1'b1};
    vecs[13] = '{32'h1008, 32'h0,        1'b0, 1'b1, SIZE_W,  1'b1, 32'h0000_0004, 1'b1};
    vecs[14] = '{32'h1004, 32'h0,        1'b0, 1'b1, SIZE_W,  1'b1, 32'h0000_0002, 1'b1};

    bus_idle();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);

    // Register access table
    for (int i = 0; i < 15; i++) begin
      io_address     = vecs[i].addr;
      io_write_value = vecs[i].wdata;
      io_write_en    = vecs[i].we;
      io_read_en     = vecs[i].re;
      io_data_size   = vecs[i].size;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_rd", i), io_read_value, vecs[i].exp_rd);
        check($sformatf("vec%0d_sel", i), {31'd0, io_sel}, {31'd0, vecs[i].exp_sel});
      end
      tick();
      bus_idle();
    end

    // Single frame at DIVISOR = 4
    do_write(32'h1000, 32'h0000_0055, SIZE_B);
    p = last_cyc;
    read_reg(32'h1004, rv);
    check("tx55_status_queued", rv, 32'h0000_0100);
    read_reg(32'h1004, rv);
    check("tx55_status_busy", rv, 32'h0000_0006);
    wait_cyc(p + 40);
    read_reg(32'h1004, rv);
    check("tx55_busy_last_cycle", rv, 32'h0000_0006);
    read_reg(32'h1004, rv);
    check("tx55_busy_cleared", rv, 32'h0000_0002);
    wait_cyc(p + 45);
    fbytes[0] = 8'h55;
    check_frames("tx55", p + 1, 4, 1, 3);

    // Overflow and back-to-back frames at DIVISOR = 2
    do_write(32'h1008, 32'h0000_0002, SIZE_W);
    for (int k = 0; k < 10; k++) begin
      io_address     = 32'h1000;
      io_write_value = 32'hA0 + k;
      io_write_en    = 1'b1;
      io_data_size   = SIZE_B;
      tick();
      if (k == 0) p = cyc;
      if (k < 9) fbytes[k] = 8'(8'hA0 + k);
    end
    bus_idle();
    read_reg(32'h1004, rv);
    check("ovf_status_set", rv, 32'h0000_080D);
    read_reg(32'h1004, rv);
    check("ovf_status_cleared", rv, 32'h0000_0805);
    wait_cyc(p + 185);
    check_frames("ovf", p + 1, 2, 9, 3);
    read_reg(32'h1004, rv);
    check("ovf_drained_status", rv, 32'h0000_0002);

    // CYCLES counter
    read_reg(32'h100C, ra);
    repeat (4) tick();
    read_reg(32'h100C, rb);
    check("cycles_delta", rb - ra, 32'd5);
    do_write(32'h100C, 32'hDEAD_BEEF, SIZE_W);
    read_reg(32'h100C, rv);
    check("cycles_cleared", rv, 32'd0);
    repeat (2) tick();
    read_reg(32'h100C, rv);
    check("cycles_after_clear", rv, 32'd3);

    // Asynchronous reset in the middle of a data bit
    do_write(32'h1008, 32'h0000_0004, SIZE_W);
    do_write(32'h1000, 32'h0000_003C, SIZE_B);
    p = last_cyc;
    do_write(32'h1000, 32'h0000_0099, SIZE_B);
    wait_cyc(p + 10);
    check("pre_reset_line_low", {31'd0, uart_tx}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_line_high", {31'd0, uart_tx}, 32'd1);
    io_address = 32'h1004;
    io_read_en = 1'b1;
    #1;
    check("reset_status_empty", io_read_value, 32'h0000_0002);
    io_address = 32'h1008;
    #1;
    check("reset_divisor", io_read_value, 32'h0000_0364);
    bus_idle();
    tick();
    reset = 1'b0;
    do_write(32'h1008, 32'h0000_0004, SIZE_W);
    do_write(32'h1000, 32'h0000_00C3, SIZE_B);
    p = last_cyc;
    wait_cyc(p + 50);
    fbytes[0] = 8'hC3;
    check_frames("post_reset", p + 1, 4, 1, 6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
